// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: registered N-to-log2(N) priority encoder with valid/ready
// handshake, a one-entry output register and an all-zero flag.
//
// Optional feature macro: PRIO_ENC_ROUND_ROBIN_EN
//   undefined : fixed priority, highest set index wins.
//   defined   : rotating priority. The search starts at ptr and moves downward,
//               wrapping modulo N. ptr resets to N-1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req        request vector, bit i = request i
//   in_valid   req is valid this cycle
//   in_ready   block can accept req this cycle (combinational)
//   out_idx    encoded index of the winning request
//   out_zero   captured req was all zeros (out_idx = 0)
//   out_valid  out_idx/out_zero hold a result
//   out_ready  consumer takes the result this cycle
module prio_enc_pipe #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_zero,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic [W-1:0] w_idx;
  logic         w_zero;
  logic [W-1:0] r_idx;
  logic         r_zero;

  // Highest set bit of v; 0 when v is empty.
  function automatic logic [W-1:0] f_hi(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Handshake: a stalled full register blocks new input.
  assign in_ready  = (r_state == EMPTY) | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_zero    = ~|req;
  assign out_valid = (r_state == FULL);
  assign out_idx   = r_idx;
  assign out_zero  = r_zero;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;
  logic [N-1:0] w_lo_mask;
  logic [N-1:0] w_lo_req;

  // Downward search from ptr with wrap: prefer the highest request at or
  // below ptr, otherwise the highest request overall (those above ptr).
  assign w_lo_mask = {N{1'b1}} >> (W'(N - 1) - r_ptr);
  assign w_lo_req  = req & w_lo_mask;

  always_comb begin
    w_idx = f_hi(req);
    if (|w_lo_req) w_idx = f_hi(w_lo_req);
  end

  // Next search starts just below the winner; wrap uses N, not 2**W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= W'(N - 1);
    end else if (w_accept && !w_zero) begin
      r_ptr <= (w_idx == '0) ? W'(N - 1) : w_idx - W'(1);
    end
  end
`else
  always_comb begin
    w_idx = f_hi(req);
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_state_nxt = FULL;
      FULL:  if (!w_accept && out_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Result register; holds its value on consume and during stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_idx  <= w_idx;
      r_zero <= w_zero;
    end
  end

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Testbench for prio_enc_pipe: N=8 and N=6 instances share the handshake
// inputs; a behavioural model predicts every output on every cycle.
module tb_prio_enc_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic [5:0] req6;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready8, zero8, valid8;
  logic [2:0] idx8;
  logic       in_ready6, zero6, valid6;
  logic [2:0] idx6;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prio_enc_pipe #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req8), .in_valid(in_valid), .in_ready(in_ready8),
    .out_idx(idx8), .out_zero(zero8), .out_valid(valid8), .out_ready(out_ready)
  );

  prio_enc_pipe #(.N(6)) u_dut6 (
    .clk(clk), .rst(rst), .req(req6), .in_valid(in_valid), .in_ready(in_ready6),
    .out_idx(idx6), .out_zero(zero6), .out_valid(valid6), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Winner of r under the selected priority rule; z=1 when r has no bits set.
  function automatic int enc(input logic [63:0] r, input int n, input int ptr, output bit z);
    z = 1'b1;
    for (int i = 0; i < n; i++) if (r[i]) z = 1'b0;
    if (z) return 0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    for (int k = 0; k < n; k++) begin
      int p;
      p = (ptr - k + n) % n;
      if (r[p]) return p;
    end
`else
    if (ptr < 0) return 0;
    for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
`endif
    return 0;
  endfunction

  // Model state per instance: occupancy (0/1), held result, rotation pointer.
  int NN[2]     = '{8, 6};
  int m_cnt[2]  = '{0, 0};
  int m_idx[2]  = '{0, 0};
  bit m_zero[2] = '{1'b0, 1'b0};
  int m_ptr[2]  = '{7, 5};
  bit m_init    = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [63:0] rq;
      int  cnt, idx, ptr, w;
      bit  zr, z;
      rq  = (d == 0) ? 64'(req8) : 64'(req6);
      cnt = m_cnt[d]; idx = m_idx[d]; zr = m_zero[d]; ptr = m_ptr[d];
      if (rst) begin
        cnt = 0; idx = 0; zr = 1'b0; ptr = NN[d] - 1;
      end else if (m_init) begin
        bit rdy;
        rdy = (cnt == 0) || out_ready;
        if (cnt != 0 && out_ready) cnt = 0;
        if (in_valid && rdy) begin
          w   = enc(rq, NN[d], ptr, z);
          cnt = 1; idx = w; zr = z;
          if (!z) ptr = (w == 0) ? NN[d] - 1 : w - 1;
        end
      end
      m_cnt[d]  <= cnt;
      m_idx[d]  <= idx;
      m_zero[d] <= zr;
      m_ptr[d]  <= ptr;
    end
    if (rst) m_init <= 1'b1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("valid8",    64'(valid8),    64'(m_cnt[0] != 0));
      chk("in_ready8", 64'(in_ready8), 64'((m_cnt[0] == 0) || out_ready));
      chk("idx8",      64'(idx8),      64'(m_idx[0]));
      chk("zero8",     64'(zero8),     64'(m_zero[0]));
      chk("valid6",    64'(valid6),    64'(m_cnt[1] != 0));
      chk("in_ready6", 64'(in_ready6), 64'((m_cnt[1] == 0) || out_ready));
      chk("idx6",      64'(idx6),      64'(m_idx[1]));
      chk("zero6",     64'(zero6),     64'(m_zero[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [7:0] r8, input bit ordy);
    in_valid  = iv;
    req8      = r8;
    req6      = r8[5:0];
    out_ready = ordy;
  endtask

  initial begin
    bit z;
    int w;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);

    // Model pins against hand-computed values.
    w = enc(64'h90, 8, 7, z); chk("model_90", 64'(w), 64'd7);
    w = enc(64'h24, 8, 7, z); chk("model_24", 64'(w), 64'd5);
    w = enc(64'h00, 8, 7, z); chk("model_zero_flag", 64'(z), 64'd1);

    // Reset for two clocks.
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid8), 64'd0);
    chk("rst_idx",   64'(idx8),   64'd0);
    chk("rst_zero",  64'(zero8),  64'd0);
    chk("rst_ready", 64'(in_ready8), 64'd1);

    // Streaming at full throughput.
    drive(1'b1, 8'b0000_0001, 1'b1); cyc();
    chk("s0_valid", 64'(valid8), 64'd1);
    chk("s0_idx",   64'(idx8),   64'd0);
    chk("s0_zero",  64'(zero8),  64'd0);
    drive(1'b1, 8'b1001_0000, 1'b1); cyc();
    chk("s1_idx",   64'(idx8),   64'd7);
    chk("s1_idx6",  64'(idx6),   64'd4);
    drive(1'b1, 8'b0000_0000, 1'b1); cyc();
    chk("s2_idx",   64'(idx8),   64'd0);
    chk("s2_zero",  64'(zero8),  64'd1);
    drive(1'b0, 8'h00, 1'b1); cyc();
    chk("s3_valid", 64'(valid8), 64'd0);

    // Stall: result held, input blocked and ignored.
    drive(1'b1, 8'h24, 1'b0); cyc();
    drive(1'b1, 8'hff, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 64'(in_ready8), 64'd0);
      chk("stall_idx",   64'(idx8),      64'd5);
      chk("stall_valid", 64'(valid8),    64'd1);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b1); #1;
    chk("unstall_ready", 64'(in_ready8), 64'd1);
    cyc();
    chk("drain_valid", 64'(valid8), 64'd0);
    chk("drain_idx",   64'(idx8),   64'd5);

    // Back-to-back with out_ready toggling 1,0,1.
    drive(1'b1, 8'h03, 1'b1); cyc();
    drive(1'b1, 8'h40, 1'b0); cyc();
    drive(1'b1, 8'h11, 1'b1); cyc();
    drive(1'b1, 8'h0c, 1'b1); cyc();
    drive(1'b0, 8'h00, 1'b1); cyc();

    // Reset while stalled discards the pending result.
    drive(1'b1, 8'h24, 1'b0); cyc();
    chk("rs_valid_pre", 64'(valid8), 64'd1);
    rst = 1'b1; drive(1'b0, 8'h00, 1'b0); cyc();
    chk("rs_valid", 64'(valid8), 64'd0);
    chk("rs_idx",   64'(idx8),   64'd0);
    rst = 1'b0; drive(1'b0, 8'h00, 1'b1); cyc();
    chk("rs_no_deliver", 64'(valid8), 64'd0);

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    // Rotation sequence and wrap at N=6.
    rst = 1'b1; cyc(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; req8 = 8'h81; req6 = 6'h21;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_idx8", 64'(idx8), (i % 2 == 0) ? 64'd7 : 64'd0);
      chk("rr_idx6", 64'(idx6), (i % 2 == 0) ? 64'd5 : 64'd0);
    end
    req8 = 8'h00; req6 = 6'h00; cyc();
    chk("rr_zero", 64'(zero8), 64'd1);
    req8 = 8'h81; req6 = 6'h21; cyc();
    chk("rr_after_zero8", 64'(idx8), 64'd7);
    chk("rr_wrap6",       64'(idx6), 64'd5);
    drive(1'b0, 8'h00, 1'b1); cyc();
`endif

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      req8      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      req6      = ($urandom_range(0, 7) == 0) ? 6'h00 : 6'($urandom);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
